// File: rtl/cond_unit_pkg.sv
// Shared definitions for the condition unit: ARM condition codes,
// NZCV flag bit positions and FlagWrite field bit positions.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Execute-side request and Memory-side result bundle of the condition unit.
// Counter outputs exist only when COND_UNIT_PERF_EN is defined.
interface cond_unit_if
`ifdef COND_UNIT_PERF_EN
    #(parameter int CNT_W = 32)
`endif
    ;

    logic       ValidE;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic [3:0] ALUFlags;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       PCSrcE;
    logic       StallE;
    logic       FlushE;

    logic       CondExE;
    logic       PCSrcGatedE;
    logic [3:0] Flags;
    logic       ValidM;
    logic       RegWriteM;
    logic       MemWriteM;
    logic       CondErrM;
`ifdef COND_UNIT_PERF_EN
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;
`endif

    modport master (
        output ValidE, CondE, FlagWriteE, ALUFlags, RegWriteE, MemWriteE,
               PCSrcE, StallE, FlushE,
        input  CondExE, PCSrcGatedE, Flags, ValidM, RegWriteM, MemWriteM,
               CondErrM
`ifdef COND_UNIT_PERF_EN
        , input ExecCount, SkipCount
`endif
    );

    modport slave (
        input  ValidE, CondE, FlagWriteE, ALUFlags, RegWriteE, MemWriteE,
               PCSrcE, StallE, FlushE,
        output CondExE, PCSrcGatedE, Flags, ValidM, RegWriteM, MemWriteM,
               CondErrM
`ifdef COND_UNIT_PERF_EN
        , output ExecCount, SkipCount
`endif
    );

endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition decode from the condition field and the
// architectural NZCV flags; also flags the reserved NV encoding.
module cond_eval
    import cond_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex,
    output logic       o_nv
);

    cond_e w_cond;
    logic  w_n, w_z, w_c, w_v;

    assign w_cond = cond_e'(i_cond);
    assign w_n    = i_flags[FLAG_N];
    assign w_z    = i_flags[FLAG_Z];
    assign w_c    = i_flags[FLAG_C];
    assign w_v    = i_flags[FLAG_V];
    assign o_nv   = (w_cond == COND_NV);

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        o_cond_ex = 1'b0;
        case (w_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition/flags unit: holds NZCV, gates the Execute controls
// and registers them into Memory. Optional counters under COND_UNIT_PERF_EN.
module cond_unit
    import cond_unit_pkg::*;
`ifdef COND_UNIT_PERF_EN
    #(parameter int CNT_W = 32)
`endif
(
    input  logic       clk,
    input  logic       reset_n,
    cond_unit_if.slave bus
);

    logic       w_cond_ex;
    logic       w_nv;
    logic       w_advance;
    logic       w_commit;
    logic [3:0] r_flags;
    logic       r_valid_m;
    logic       r_reg_write_m;
    logic       r_mem_write_m;
    logic       r_cond_err_m;

    cond_eval u_cond_eval (
        .i_cond    (bus.CondE),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex),
        .o_nv      (w_nv)
    );

    // Stall and flush both turn this cycle into a Memory-stage bubble.
    assign w_advance = ~bus.StallE & ~bus.FlushE;
    assign w_commit  = bus.ValidE & w_cond_ex & w_advance;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags       <= 4'b0000;
            r_valid_m     <= 1'b0;
            r_reg_write_m <= 1'b0;
            r_mem_write_m <= 1'b0;
            r_cond_err_m  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (w_commit && bus.FlagWriteE[FW_NZ]) begin
                r_flags[FLAG_N] <= bus.ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
            end
            if (w_commit && bus.FlagWriteE[FW_CV]) begin
                r_flags[FLAG_C] <= bus.ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= bus.ALUFlags[FLAG_V];
            end
            r_valid_m     <= w_commit;
            r_reg_write_m <= bus.RegWriteE & w_commit;
            r_mem_write_m <= bus.MemWriteE & w_commit;
            r_cond_err_m  <= bus.ValidE & w_nv & ~bus.FlushE;
        end
    end

    assign bus.CondExE     = w_cond_ex;
    assign bus.PCSrcGatedE = bus.PCSrcE & w_commit;
    assign bus.Flags       = r_flags;
    assign bus.ValidM      = r_valid_m;
    assign bus.RegWriteM   = r_reg_write_m;
    assign bus.MemWriteM   = r_mem_write_m;
    assign bus.CondErrM    = r_cond_err_m;

`ifdef COND_UNIT_PERF_EN
    logic             w_skip;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_skip_cnt;

    assign w_skip = bus.ValidE & ~w_cond_ex & w_advance;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else begin
            if (w_commit && !(&r_exec_cnt)) r_exec_cnt <= r_exec_cnt + CNT_W'(1);
            if (w_skip && !(&r_skip_cnt))   r_skip_cnt <= r_skip_cnt + CNT_W'(1);
        end
    end

    assign bus.ExecCount = r_exec_cnt;
    assign bus.SkipCount = r_skip_cnt;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios then random traffic,
// compared against a flag/condition reference model held in the bench.
module tb_cond_unit;

`ifdef COND_UNIT_PERF_EN
    localparam int CNT_W = 4;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
`endif

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

`ifdef COND_UNIT_PERF_EN
    cond_unit_if #(.CNT_W(CNT_W)) bus ();
    cond_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
    cond_unit_if bus ();
    cond_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [3:0] m_flags;
    logic       m_valid_m, m_rw_m, m_mw_m, m_err_m;
    longint     m_exec, m_skip;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Condition codes pair up: even code = base predicate, odd code = its inverse.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic model_reset();
        m_flags   = 4'b0000;
        m_valid_m = 1'b0;
        m_rw_m    = 1'b0;
        m_mw_m    = 1'b0;
        m_err_m   = 1'b0;
        m_exec    = 0;
        m_skip    = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".flags"}, 32'(bus.Flags), 32'(m_flags));
        check({tag, ".valid_m"}, 32'(bus.ValidM), 32'(m_valid_m));
        check({tag, ".regwrite_m"}, 32'(bus.RegWriteM), 32'(m_rw_m));
        check({tag, ".memwrite_m"}, 32'(bus.MemWriteM), 32'(m_mw_m));
        check({tag, ".conderr_m"}, 32'(bus.CondErrM), 32'(m_err_m));
`ifdef COND_UNIT_PERF_EN
        check({tag, ".exec_cnt"}, 32'(bus.ExecCount), 32'((m_exec > CNT_MAX) ? CNT_MAX : m_exec));
        check({tag, ".skip_cnt"}, 32'(bus.SkipCount), 32'((m_skip > CNT_MAX) ? CNT_MAX : m_skip));
`endif
    endtask

    // One Execute cycle: drive at negedge, check combinational outputs,
    // advance the model at posedge, check registered outputs just after.
    task automatic step(input string tag, input logic v, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] af,
                        input logic rw, input logic mw, input logic pcs,
                        input logic st, input logic fl);
        logic ex, commit;
        @(negedge clk);
        bus.ValidE     = v;
        bus.CondE      = c;
        bus.FlagWriteE = fw;
        bus.ALUFlags   = af;
        bus.RegWriteE  = rw;
        bus.MemWriteE  = mw;
        bus.PCSrcE     = pcs;
        bus.StallE     = st;
        bus.FlushE     = fl;
        #1;
        ex     = cond_holds(c, m_flags);
        commit = v && ex && !st && !fl;
        check({tag, ".cond_ex"}, 32'(bus.CondExE), 32'(ex));
        check({tag, ".pcsrc_gated"}, 32'(bus.PCSrcGatedE), 32'(pcs && commit));
        @(posedge clk);
        if (commit && fw[1]) m_flags[3:2] = af[3:2];
        if (commit && fw[0]) m_flags[1:0] = af[1:0];
        m_valid_m = commit;
        m_rw_m    = rw && commit;
        m_mw_m    = mw && commit;
        m_err_m   = v && (c == 4'hF) && !fl;
        if (commit) m_exec++;
        if (v && !ex && !st && !fl) m_skip++;
        #1;
        check_regs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        reset_n        = 1'b0;
        bus.ValidE     = 1'b0;
        bus.CondE      = 4'h0;
        bus.FlagWriteE = 2'b00;
        bus.ALUFlags   = 4'h0;
        bus.RegWriteE  = 1'b0;
        bus.MemWriteE  = 1'b0;
        bus.PCSrcE     = 1'b0;
        bus.StallE     = 1'b0;
        bus.FlushE     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Z set by an AL instruction, then EQ sees it
        step("al_setz", 1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 0, 0);
        check("al_setz.flags_const", 32'(bus.Flags), 32'h4);
        step("eq_taken", 1, 4'h0, 2'b00, 4'b0000, 1, 0, 1, 0, 0);
        check("eq_taken.regwrite_const", 32'(bus.RegWriteM), 32'h1);

        // N=1,V=1: signed comparisons; failing ones must not write flags
        step("set_nv", 1, 4'hE, 2'b11, 4'b1001, 0, 0, 0, 0, 0);
        step("ge", 1, 4'hA, 2'b00, 4'b0000, 1, 0, 0, 0, 0);
        step("lt_nowrite", 1, 4'hB, 2'b11, 4'b0110, 1, 1, 1, 0, 0);
        check("lt_nowrite.flags_const", 32'(bus.Flags), 32'h9);
        step("gt", 1, 4'hC, 2'b00, 4'b0000, 0, 1, 0, 0, 0);
        step("le_nowrite", 1, 4'hD, 2'b11, 4'b0110, 1, 1, 1, 0, 0);

        // Partial flag write: only N,Z
        step("clear", 1, 4'hE, 2'b11, 4'b0000, 0, 0, 0, 0, 0);
        step("fw_nz", 1, 4'hE, 2'b10, 4'b1111, 0, 0, 0, 0, 0);
        check("fw_nz.flags_const", 32'(bus.Flags), 32'hC);
        step("fw_cv", 1, 4'hE, 2'b01, 4'b0010, 0, 0, 0, 0, 0);

        // Stall / flush / both: bubble and flags hold
        step("stall", 1, 4'hE, 2'b11, 4'b0011, 1, 1, 1, 1, 0);
        step("flush", 1, 4'hE, 2'b11, 4'b0011, 1, 1, 1, 0, 1);
        step("stall_flush", 1, 4'hE, 2'b11, 4'b0011, 1, 1, 1, 1, 1);

        // NV: never commits, one-cycle error pulse
        step("nv", 1, 4'hF, 2'b11, 4'b1111, 1, 1, 1, 0, 0);
        step("nv_after", 0, 4'hE, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        step("nv_flush", 1, 4'hF, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
        step("invalid", 0, 4'hE, 2'b11, 4'b1111, 1, 1, 1, 0, 0);

        // Asynchronous reset between clock edges
        step("pre_reset", 1, 4'hE, 2'b11, 4'b1010, 1, 1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step("post_reset", 1, 4'hE, 2'b11, 4'b0110, 1, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 logic'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
